pa_icache_loader: RTL and testbench

//  Parametrised instruction-cache program loader for PA_Core. It accepts instruction bundles over a valid/ready stream and buffers them in a FIFO.
//  It writes them to consecutive i-cache addresses through the core's icacheWriteEnable/writeAddress/instruction port.
//  The core is held in reset while loading and released a fixed number of cycles after the last write.

---
 rtl/pa_icache_loader.sv | 202 ++++++++++++++++++++
 tb/tb_pa_icache_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_icache_loader.sv
// Boot loader for PA_Core: buffers instruction bundles from a valid/ready stream in a FIFO,
// writes them to consecutive i-cache addresses, then releases the core from reset.
module pa_icache_loader #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 30,
  parameter int unsigned LANES       = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BOOT_HOLD   = 2
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        baseAddr_i,
  input  logic [ADDR_WIDTH-1:0]        count_i,
  input  logic                         bundleValid_i,
  input  logic [LANES*INSTR_WIDTH-1:0] bundle_i,
  output logic                         bundleReady_o,
  input  logic                         writeStall_i,
  output logic                         icacheWriteEnable_o,
  output logic [ADDR_WIDTH-1:0]        writeAddress_o,
  output logic [LANES*INSTR_WIDTH-1:0] instruction_o,
  output logic                         coreReset_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int unsigned BW    = LANES * INSTR_WIDTH;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned HoldW = $clog2(BOOT_HOLD + 1);
  localparam logic [ADDR_WIDTH:0] AddrSpan = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StHold, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] accepted_q, accepted_d;
  logic [ADDR_WIDTH-1:0] presented_q, presented_d;
  logic [ADDR_WIDTH-1:0] written_q, written_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         data_q, data_d;
  logic                  core_rst_q, core_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [BW-1:0]         fifo_mem [FIFO_DEPTH];
  logic                  push, present, wr_done, overrun;
  logic [ADDR_WIDTH:0]   addr_end;

  // The slot under the current write stays occupied until that write retires, so the
  // FIFO occupancy includes the in-flight entry.
  assign bundleReady_o = (state_q == StLoad) && (occ_q != OccW'(FIFO_DEPTH)) &&
                         (accepted_q < count_q);
  assign push     = bundleValid_i && bundleReady_o;
  assign wr_done  = we_q && !writeStall_i;
  assign present  = (!we_q || !writeStall_i) && (occ_q > OccW'(we_q));
  assign addr_end = {1'b0, baseAddr_i} + {1'b0, count_i};
  assign overrun  = addr_end > AddrSpan;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    accepted_d  = accepted_q;
    presented_d = presented_q;
    written_d   = written_q;
    hold_d      = hold_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    core_rst_d  = core_rst_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    if (push) begin
      wptr_d     = wptr_q + 1'b1;
      accepted_d = accepted_q + 1'b1;
    end
    if (present) begin
      rptr_d      = rptr_q + 1'b1;
      we_d        = 1'b1;
      addr_d      = base_q + presented_q;
      data_d      = fifo_mem[rptr_q];
      presented_d = presented_q + 1'b1;
    end else if (wr_done) begin
      we_d = 1'b0;
    end
    if (wr_done) begin
      written_d = written_q + 1'b1;
    end
    occ_d = occ_q + OccW'(push) - OccW'(wr_done);

    case (state_q)
      StIdle, StRun: begin
        if (start_i) begin
          if (overrun) begin
            error_d = 1'b1;
          end else begin
            error_d     = 1'b0;
            core_rst_d  = 1'b1;
            busy_d      = 1'b1;
            base_d      = baseAddr_i;
            count_d     = count_i;
            accepted_d  = '0;
            presented_d = '0;
            written_d   = '0;
            hold_d      = '0;
            state_d     = (count_i == '0) ? StHold : StLoad;
          end
        end
      end
      StLoad: begin
        if (accepted_d == count_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (wr_done && (written_d == count_q)) begin
          state_d = StHold;
          hold_d  = '0;
        end
      end
      StHold: begin
        if (hold_q == HoldW'(BOOT_HOLD - 1)) begin
          state_d    = StRun;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      count_q     <= '0;
      accepted_q  <= '0;
      presented_q <= '0;
      written_q   <= '0;
      hold_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      accepted_q  <= accepted_d;
      presented_q <= presented_d;
      written_q   <= written_d;
      hold_q      <= hold_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_mem[wptr_q] <= bundle_i;
    end
  end

  assign icacheWriteEnable_o = we_q;
  assign writeAddress_o      = addr_q;
  assign instruction_o       = data_q;
  assign coreReset_o         = core_rst_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_pa_icache_loader.sv
// Bench for pa_icache_loader: directed scenarios plus randomized sessions, with a write
// scoreboard fed by the driver and drained by a monitor that watches completed i-cache writes.
module tb_pa_icache_loader;

  localparam int AW    = 16;
  localparam int IW    = 30;
  localparam int LN    = 2;
  localparam int BW    = IW * LN;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] baseAddr_i = '0;
  logic [AW-1:0] count_i = '0;
  logic          bundleValid_i = 1'b0;
  logic [BW-1:0] bundle_i = '0;
  logic          bundleReady_o;
  logic          writeStall_i = 1'b0;
  logic          icacheWriteEnable_o;
  logic [AW-1:0] writeAddress_o;
  logic [BW-1:0] instruction_o;
  logic          coreReset_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  pa_icache_loader #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .LANES      (LN),
    .FIFO_DEPTH (DEPTH),
    .BOOT_HOLD  (HOLD)
  ) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .baseAddr_i         (baseAddr_i),
    .count_i            (count_i),
    .bundleValid_i      (bundleValid_i),
    .bundle_i           (bundle_i),
    .bundleReady_o      (bundleReady_o),
    .writeStall_i       (writeStall_i),
    .icacheWriteEnable_o(icacheWriteEnable_o),
    .writeAddress_o     (writeAddress_o),
    .instruction_o      (instruction_o),
    .coreReset_o        (coreReset_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  wr_cycles[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  fall_cyc = -1;
  logic core_prev = 1'b1;

  // Reference model of the active session: expected address = base + acceptance index.
  logic [AW-1:0] sess_base = '0;
  int            sess_idx = 0;
  bit            rand_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
    if (rand_stall) writeStall_i = ($urandom_range(0, 99) < 35);
  endtask

  task automatic monitor_loop();
    wr_t exp;
    forever begin
      @(negedge clock_i);
      if (icacheWriteEnable_o && !writeStall_i) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   writeAddress_o, instruction_o);
        end else begin
          exp = sb.pop_front();
          if (writeAddress_o !== exp.addr || instruction_o !== exp.data) begin
            n_errors++;
            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                     writeAddress_o, instruction_o, exp.addr, exp.data);
          end
        end
        wr_cnt++;
        wr_cycles.push_back(cyc + 1);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (core_prev && !coreReset_o) fall_cyc = cyc;
      core_prev = coreReset_o;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c, output bit ovr);
    ovr = (int'(b) + int'(c)) > (1 << AW);
    start_i = 1'b1;
    baseAddr_i = b;
    count_i = c;
    tick();
    start_i = 1'b0;
    if (!ovr) begin
      sess_base = b;
      sess_idx = 0;
    end
  endtask

  task automatic start_ignored(input logic [AW-1:0] b, input logic [AW-1:0] c);
    start_i = 1'b1;
    baseAddr_i = b;
    count_i = c;
    tick();
    start_i = 1'b0;
  endtask

  // Offers one bundle and leaves valid high; the caller drops valid when the burst ends.
  task automatic feed_one(input logic [BW-1:0] d, input int maxc, output bit ok);
    wr_t e;
    bundle_i = d;
    bundleValid_i = 1'b1;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock_i);
      if (bundleReady_o) begin
        e.addr = sess_base + AW'(sess_idx);
        e.data = d;
        sb.push_back(e);
        sess_idx++;
        ok = 1;
      end
      tick();
      if (ok) break;
    end
  endtask

  task automatic wait_idle(input int maxc);
    bit hit = 0;
    for (int i = 0; i < maxc; i++) begin
      if (!busy_o && sb.size() == 0) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("idle_timeout", 64'(hit), 64'd1);
    tick();
  endtask

  function automatic logic [BW-1:0] rnd_bundle();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  initial begin
    bit            ovr, ok;
    int            w0, d0, acc, s;
    logic [BW-1:0] d[6];
    logic [AW-1:0] b, c;

    fork
      monitor_loop();
    join_none

    // 1: reset values
    tick();
    chk("rst_core_reset", 64'(coreReset_o), 64'd1);
    chk("rst_we", 64'(icacheWriteEnable_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(bundleReady_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(writeAddress_o), 64'd0);
    chk("rst_instr", 64'(instruction_o), 64'd0);
    reset_i = 1'b0;
    tick();

    // 2: three bundles back-to-back, no stall
    w0 = wr_cnt; d0 = done_cnt; wr_cycles.delete(); fall_cyc = -1;
    do_start(16'd5, 16'd3, ovr);
    chk("t2_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      feed_one(rnd_bundle(), 10, ok);
      chk("t2_accept", 64'(ok), 64'd1);
    end
    bundleValid_i = 1'b0;
    wait_idle(50);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd3);
    if (wr_cycles.size() == 3) begin
      chk("t2_consecutive", 64'(wr_cycles[2] - wr_cycles[0]), 64'd2);
      chk("t2_release", 64'(fall_cyc), 64'(wr_cycles[2] + HOLD));
    end
    chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t2_done_at_release", 64'(done_cyc), 64'(fall_cyc));
    chk("t2_core_run", 64'(coreReset_o), 64'd0);

    // 3: stall throughout: FIFO fills, head write held
    w0 = wr_cnt;
    writeStall_i = 1'b1;
    do_start(16'd100, 16'd6, ovr);
    for (int k = 0; k < 6; k++) d[k] = rnd_bundle();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      feed_one(d[k], 8, ok);
      if (!ok) break;
      acc++;
    end
    chk("t3_accepted", 64'(acc), 64'(DEPTH));
    chk("t3_ready_low", 64'(bundleReady_o), 64'd0);
    chk("t3_we_held", 64'(icacheWriteEnable_o), 64'd1);
    chk("t3_addr_held", 64'(writeAddress_o), 64'd100);
    chk("t3_data_held", 64'(instruction_o), 64'(d[0]));
    chk("t3_no_writes", 64'(wr_cnt - w0), 64'd0);
    writeStall_i = 1'b0;
    for (int k = acc; k < 6; k++) begin
      feed_one(d[k], 20, ok);
      chk("t3_accept_rest", 64'(ok), 64'd1);
    end
    bundleValid_i = 1'b0;
    wait_idle(60);
    chk("t3_writes", 64'(wr_cnt - w0), 64'd6);

    // 4: overrun rejected from RUN, then a good start clears error
    w0 = wr_cnt;
    do_start(16'hFFFE, 16'd3, ovr);
    chk("t4_model_ovr", 64'(ovr), 64'd1);
    chk("t4_error", 64'(error_o), 64'd1);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_core", 64'(coreReset_o), 64'd0);
    repeat (4) tick();
    chk("t4_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t4_error_sticky", 64'(error_o), 64'd1);
    do_start(16'd0, 16'd1, ovr);
    chk("t4_error_clr", 64'(error_o), 64'd0);
    chk("t4_core_held", 64'(coreReset_o), 64'd1);
    feed_one(rnd_bundle(), 10, ok);
    bundleValid_i = 1'b0;
    wait_idle(40);
    chk("t4_writes", 64'(wr_cnt - w0), 64'd1);

    // 6a: count=0 from RUN
    w0 = wr_cnt; d0 = done_cnt; fall_cyc = -1;
    do_start(16'd7, 16'd0, ovr);
    s = cyc;
    chk("t6_core", 64'(coreReset_o), 64'd1);
    chk("t6_busy", 64'(busy_o), 64'd1);
    wait_idle(30);
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t6_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t6_done_cyc", 64'(done_cyc), 64'(s + HOLD));
    chk("t6_release_cyc", 64'(fall_cyc), 64'(s + HOLD));

    // 6b: start during LOAD ignored
    w0 = wr_cnt;
    do_start(16'd400, 16'd3, ovr);
    feed_one(rnd_bundle(), 10, ok);
    bundleValid_i = 1'b0;
    start_ignored(16'd50, 16'd5);
    chk("t6b_error", 64'(error_o), 64'd0);
    chk("t6b_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < 2; k++) feed_one(rnd_bundle(), 10, ok);
    feed_one(rnd_bundle(), 6, ok);
    chk("t6b_count_kept", 64'(ok), 64'd0);
    bundleValid_i = 1'b0;
    wait_idle(40);
    chk("t6b_writes", 64'(wr_cnt - w0), 64'd3);

    // 5: reset after two of four writes
    w0 = wr_cnt;
    writeStall_i = 1'b1;
    do_start(16'd200, 16'd4, ovr);
    for (int k = 0; k < 4; k++) feed_one(rnd_bundle(), 10, ok);
    bundleValid_i = 1'b0;
    writeStall_i = 1'b0;
    tick();
    tick();
    writeStall_i = 1'b1;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    sb.delete();
    chk("t5_we", 64'(icacheWriteEnable_o), 64'd0);
    chk("t5_core", 64'(coreReset_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_ready", 64'(bundleReady_o), 64'd0);
    chk("t5_writes", 64'(wr_cnt - w0), 64'd2);
    writeStall_i = 1'b0;
    tick();
    w0 = wr_cnt;
    do_start(16'd300, 16'd2, ovr);
    for (int k = 0; k < 2; k++) feed_one(rnd_bundle(), 10, ok);
    bundleValid_i = 1'b0;
    wait_idle(40);
    chk("t5_new_writes", 64'(wr_cnt - w0), 64'd2);

    // Randomized sessions with random gaps and stalls
    rand_stall = 1;
    for (int n = 0; n < 14; n++) begin
      b = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 3) == 0) b = AW'((1 << AW) - int'($urandom_range(1, 6)));
      c = AW'($urandom_range(0, 10));
      w0 = wr_cnt; d0 = done_cnt;
      do_start(b, c, ovr);
      chk("rnd_error", 64'(error_o), 64'(ovr));
      chk("rnd_busy", 64'(busy_o), 64'(!ovr));
      if (!ovr) begin
        for (int k = 0; k < int'(c); k++) begin
          if ($urandom_range(0, 2) == 0) begin
            bundleValid_i = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
          end
          feed_one(rnd_bundle(), 200, ok);
          chk("rnd_accept", 64'(ok), 64'd1);
        end
        bundleValid_i = 1'b0;
        wait_idle(600);
        chk("rnd_writes", 64'(wr_cnt - w0), 64'(c));
        chk("rnd_done", 64'(done_cnt - d0), 64'd1);
      end
    end
    rand_stall = 0;
    writeStall_i = 1'b0;
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
